// File: rtl/bcd_updown_timer.sv
`timescale 1ns/1ps
// BCD up/down timer: prescaled count tick, sync clear/load, wrap or saturate
// at the range ends, lap-hold display freeze and tick/terminal status.
module bcd_updown_timer #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DVSR   = 10000000,
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned WRAP   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                lap_hold,
  output logic [4*DIGITS-1:0] digits,
  output logic                tick,
  output logic                terminal,
  output logic                saturated
);

  localparam int unsigned      W       = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DVSR - 1);
  localparam logic [W-1:0]     ALL9    = {DIGITS{4'h9}};
  localparam bit               WRAP_EN = (WRAP != 0);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [W-1:0]     count_q, count_d;
  logic [W-1:0]     lap_q;
  logic             lap_prev_q;
  logic             terminal_q, terminal_d;

  logic [W-1:0]     step_val;
  logic [W-1:0]     clamped;
  logic [W-1:0]     end_val;
  logic             at_end;
  logic             carry;
  logic [3:0]       nib;

  assign tick      = enable && (presc_q == LAST);
  assign end_val   = up ? ALL9 : '0;
  assign at_end    = (count_q == end_val);
  assign saturated = !WRAP_EN && at_end;
  assign terminal  = terminal_q;
  // The rising-edge cycle shows the live count, which is what lap_q captures.
  assign digits    = (lap_hold && lap_prev_q) ? lap_q : count_q;

  always_comb begin
    clamped = load_value;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'h9;
    end
  end

  // Ripple carry/borrow through the decades; an all-9s/all-0s input wraps.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    nib      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (nib >= 4'd9) step_val[4*i +: 4] = 4'd0;
          else begin
            step_val[4*i +: 4] = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) step_val[4*i +: 4] = 4'd9;
          else begin
            step_val[4*i +: 4] = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    terminal_d = 1'b0;
    if (clear) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = clamped;
      presc_d = '0;
    end else if (enable) begin
      presc_d = tick ? '0 : presc_q + CNT_W'(1);
      if (tick) begin
        if (!saturated) count_d = step_val;
        terminal_d = WRAP_EN ? at_end : (!at_end && (step_val == end_val));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      lap_prev_q <= 1'b0;
      terminal_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      terminal_q <= terminal_d;
      lap_prev_q <= lap_hold;
      if (lap_hold && !lap_prev_q) lap_q <= count_q;
    end
  end

endmodule

// File: tb/tb_bcd_updown_timer.sv
`timescale 1ns/1ps
// Directed bench: a wrapping and a saturating 2-digit timer (DVSR=4) driven
// in lockstep, checked against hand-computed values.
module tb_bcd_updown_timer;

  logic       clk = 1'b0;
  logic       reset, enable, up, clear, load, lap_hold;
  logic [7:0] load_value;
  logic [7:0] dw_digits, ds_digits;
  logic       dw_tick, ds_tick, dw_term, ds_term, dw_sat, ds_sat;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bcd_updown_timer #(.DIGITS(2), .DVSR(4), .CNT_W(3), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .lap_hold(lap_hold),
    .digits(dw_digits), .tick(dw_tick), .terminal(dw_term), .saturated(dw_sat)
  );

  bcd_updown_timer #(.DIGITS(2), .DVSR(4), .CNT_W(3), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .lap_hold(lap_hold),
    .digits(ds_digits), .tick(ds_tick), .terminal(ds_term), .saturated(ds_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From prescaler 0: three cycles to the tick cycle, then the counting edge.
  task automatic do_tick();
    repeat (3) cyc();
    chk("tick_w", {31'd0, dw_tick}, 32'd1);
    chk("tick_s", {31'd0, ds_tick}, 32'd1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0;
    lap_hold = 1'b0; load_value = 8'h00;
    cyc(); cyc();
    chk("rst_digits_w", {24'd0, dw_digits}, 32'h00);
    chk("rst_digits_s", {24'd0, ds_digits}, 32'h00);
    chk("rst_term_w", {31'd0, dw_term}, 32'd0);
    chk("rst_sat_up_s", {31'd0, ds_sat}, 32'd0);
    chk("rst_sat_w", {31'd0, dw_sat}, 32'd0);
    up = 1'b0; #1;
    chk("rst_sat_dn_s", {31'd0, ds_sat}, 32'd1);
    up = 1'b1; #1;

    // Free-running count up, 10 ticks.
    reset = 1'b0; enable = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      cyc();
      chk("tick_gap", {31'd0, dw_tick}, 32'd0);
      cyc(); cyc();
      chk("tick_on", {31'd0, dw_tick}, 32'd1);
      cyc();
      chk("count_up", {24'd0, dw_digits}, 32'((t / 10) * 16 + (t % 10)));
      chk("count_term", {31'd0, dw_term}, 32'd0);
    end
    chk("count10_s", {24'd0, ds_digits}, 32'h10);

    // Wrap at 99 going up, then at 00 going down.
    load = 1'b1; load_value = 8'h99; cyc(); load = 1'b0;
    chk("load99", {24'd0, dw_digits}, 32'h99);
    do_tick();
    chk("wrap_up_w", {24'd0, dw_digits}, 32'h00);
    chk("wrap_up_term_w", {31'd0, dw_term}, 32'd1);
    chk("sat99_s", {24'd0, ds_digits}, 32'h99);
    chk("sat99_term_s", {31'd0, ds_term}, 32'd0);
    chk("sat99_flag_s", {31'd0, ds_sat}, 32'd1);
    up = 1'b0; #1;
    chk("sat_dn_s", {31'd0, ds_sat}, 32'd0);
    do_tick();
    chk("wrap_dn_w", {24'd0, dw_digits}, 32'h99);
    chk("wrap_dn_term_w", {31'd0, dw_term}, 32'd1);
    chk("dn_s", {24'd0, ds_digits}, 32'h98);
    cyc();
    chk("term_1cyc_w", {31'd0, dw_term}, 32'd0);

    // Saturating run into 99.
    up = 1'b1; load = 1'b1; load_value = 8'h98; cyc(); load = 1'b0;
    do_tick();
    chk("reach99_s", {24'd0, ds_digits}, 32'h99);
    chk("reach99_term_s", {31'd0, ds_term}, 32'd1);
    chk("reach99_sat_s", {31'd0, ds_sat}, 32'd1);
    chk("reach99_term_w", {31'd0, dw_term}, 32'd0);
    do_tick();
    chk("hold99_s", {24'd0, ds_digits}, 32'h99);
    chk("hold99_term_s", {31'd0, ds_term}, 32'd0);
    chk("wrap00_w", {24'd0, dw_digits}, 32'h00);
    do_tick();
    chk("hold99b_s", {24'd0, ds_digits}, 32'h99);
    chk("hold99b_term_s", {31'd0, ds_term}, 32'd0);
    chk("w01", {24'd0, dw_digits}, 32'h01);
    up = 1'b0; #1;
    chk("unsat_s", {31'd0, ds_sat}, 32'd0);
    do_tick();
    chk("leave99_s", {24'd0, ds_digits}, 32'h98);
    chk("down00_w", {24'd0, dw_digits}, 32'h00);
    chk("down00_term_w", {31'd0, dw_term}, 32'd0);
    up = 1'b1;

    // Clamped load, and load colliding with a tick.
    load = 1'b1; load_value = 8'h3C; cyc(); load = 1'b0;
    chk("clamp_w", {24'd0, dw_digits}, 32'h39);
    chk("clamp_s", {24'd0, ds_digits}, 32'h39);
    repeat (3) cyc();
    chk("pre_load_tick", {31'd0, dw_tick}, 32'd1);
    load = 1'b1; cyc(); load = 1'b0;
    chk("load_wins", {24'd0, dw_digits}, 32'h39);
    chk("load_no_term", {31'd0, dw_term}, 32'd0);
    cyc(); chk("restart_t1", {31'd0, dw_tick}, 32'd0);
    cyc(); chk("restart_t2", {31'd0, dw_tick}, 32'd0);
    cyc(); chk("restart_t3", {31'd0, dw_tick}, 32'd1);
    cyc(); chk("after_restart", {24'd0, dw_digits}, 32'h40);

    // Lap hold freezes the display while the count runs on.
    load = 1'b1; load_value = 8'h12; cyc(); load = 1'b0;
    lap_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_tick();
      chk("lap_frozen", {24'd0, dw_digits}, 32'h12);
    end
    lap_hold = 1'b0; #1;
    chk("lap_release_w", {24'd0, dw_digits}, 32'h17);
    chk("lap_release_s", {24'd0, ds_digits}, 32'h17);

    // Pause mid-prescale, resume, then clear+load together.
    cyc(); cyc();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("paused_tick", {31'd0, dw_tick}, 32'd0);
    end
    chk("paused_digits", {24'd0, dw_digits}, 32'h17);
    enable = 1'b1; #1;
    chk("resume_t0", {31'd0, dw_tick}, 32'd0);
    cyc();
    chk("resume_t1", {31'd0, dw_tick}, 32'd1);
    cyc();
    chk("resume_count", {24'd0, dw_digits}, 32'h18);
    clear = 1'b1; load = 1'b1; load_value = 8'h55; cyc();
    clear = 1'b0; load = 1'b0;
    chk("clr_wins_w", {24'd0, dw_digits}, 32'h00);
    chk("clr_wins_s", {24'd0, ds_digits}, 32'h00);
    chk("clr_no_term", {31'd0, dw_term}, 32'd0);

    // Load during hold touches only the live count; reset drops the hold.
    load = 1'b1; load_value = 8'h42; cyc(); load = 1'b0;
    lap_hold = 1'b1; cyc();
    load = 1'b1; load_value = 8'h07; cyc(); load = 1'b0;
    chk("hold_load", {24'd0, dw_digits}, 32'h42);
    reset = 1'b1; cyc();
    chk("rst_hold_w", {24'd0, dw_digits}, 32'h00);
    chk("rst_hold_term", {31'd0, dw_term}, 32'd0);
    reset = 1'b0; lap_hold = 1'b0; cyc();
    chk("post_rst_s", {24'd0, ds_digits}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
